// File: rtl/exec01_seq_pkg.sv
// Shared types and constants for the exec01 operand sequencer.
package exec01_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int NUM_BEATS = 4;
  localparam int BEAT_A    = 0;
  localparam int BEAT_B    = 1;
  localparam int BEAT_C    = 2;
  localparam int BEAT_F    = 3;
  localparam int CNT_W     = $clog2(NUM_BEATS);

  // Beat index comparison at the counter's own width.
  function automatic logic beat_is(input logic [CNT_W-1:0] cnt, input int idx);
    return cnt == CNT_W'(idx);
  endfunction

endpackage

// File: rtl/exec01_operand_seq_if.sv
// Operand-in and result-out valid/ready streams of the exec01 sequencer.
interface exec01_operand_seq_if #(parameter int WIDTH = 5) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ctrl;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  // master: producer of operand beats and consumer of results
  modport master (
    output in_valid, in_data, in_ctrl, res_ready,
    input  in_ready, res_valid, res_data
  );

  // slave: the sequencer itself
  modport slave (
    input  in_valid, in_data, in_ctrl, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/exec01_operand_seq.sv
// exec01 operand sequencer: loads a, b, c, f serially (ctrl on the last beat),
// holds them stable for exec01 for one cycle, captures d and returns it on a
// valid/ready result stream.
// Optional: define EXEC01_SEQ_COUNT_EN to add an 8-bit result handshake counter.
module exec01_operand_seq
  import exec01_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  exec01_operand_seq_if.slave io,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] f,
  output logic             ctrl,
  input  logic [WIDTH-1:0] d,
`ifdef EXEC01_SEQ_COUNT_EN
  output logic [7:0]       txn_count,
`endif
  output logic             busy
);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             beat_fire;
  logic             res_fire;

  assign beat_fire = io.in_valid && io.in_ready;
  assign res_fire  = io.res_valid && io.res_ready;

  // Sequencer FSM; all handshake outputs and operands are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      a            <= '0;
      b            <= '0;
      c            <= '0;
      f            <= '0;
      ctrl         <= 1'b0;
      io.res_data  <= '0;
      io.res_valid <= 1'b0;
      io.in_ready  <= 1'b0;   // rises on the first edge out of reset
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          io.in_ready <= 1'b1;
          busy        <= 1'b0;
          if (beat_fire) begin
            a     <= io.in_data;
            cnt   <= CNT_W'(BEAT_B);
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (beat_fire) begin
            if (beat_is(cnt, BEAT_B)) begin
              b   <= io.in_data;
              cnt <= CNT_W'(BEAT_C);
            end else if (beat_is(cnt, BEAT_C)) begin
              c   <= io.in_data;
              cnt <= CNT_W'(BEAT_F);
            end else begin
              // last beat: ctrl is only taken here
              f           <= io.in_data;
              ctrl        <= io.in_ctrl;
              cnt         <= '0;
              io.in_ready <= 1'b0;
              state       <= EXEC;
            end
          end
        end
        EXEC: begin
          // operands have been stable for this whole cycle; take exec01's result
          io.res_data  <= d;
          io.res_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (res_fire) begin
            io.res_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXEC01_SEQ_COUNT_EN
  // Result handshake counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)        txn_count <= '0;
    else if (res_fire) txn_count <= txn_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_exec01_operand_seq.sv
// Self-checking bench for exec01_operand_seq; d comes from a bench-side stub.
module tb_exec01_operand_seq;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, c, f, d;
  logic         ctrl, busy;
`ifdef EXEC01_SEQ_COUNT_EN
  logic [7:0]   txn_count;
`endif

  logic         d_ovr = 1'b0;
  logic [W-1:0] d_val = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;
  logic [W-1:0] exp_q[$];

  exec01_operand_seq_if #(.WIDTH(W)) io ();

  exec01_operand_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .a(a), .b(b), .c(c), .f(f), .ctrl(ctrl), .d(d),
`ifdef EXEC01_SEQ_COUNT_EN
    .txn_count(txn_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // exec01 stand-in: a fixed combinational mix of the presented operands
  always_comb d = d_ovr ? d_val : (a ^ b ^ c ^ f ^ {W{ctrl}});

  function automatic logic [W-1:0] model(input logic [W-1:0] ba, bb, bc, bf,
                                         input logic ct);
    return ba ^ bb ^ bc ^ bf ^ {W{ct}};
  endfunction

  // Drives one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [W-1:0] dat, input logic ct);
    int t = 0;
    io.in_valid = 1'b1; io.in_data = dat; io.in_ctrl = ct;
    while (!io.in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout in_ready=%0b required 1", io.in_ready);
    end
    @(negedge clk);
    io.in_valid = 1'b0; io.in_data = '0; io.in_ctrl = 1'b0;
  endtask

  task automatic send_seq(input logic [W-1:0] v0, v1, v2, v3, input logic ct,
                          input bit bubble, input bit push);
    send_beat(v0, ~ct); if (bubble) @(negedge clk);
    send_beat(v1, ~ct); if (bubble) @(negedge clk);
    send_beat(v2, ~ct); if (bubble) @(negedge clk);
    send_beat(v3, ct);
    if (push) exp_q.push_back(model(v0, v1, v2, v3, ct));
  endtask

  // Waits for a result, stalls for 'hold' cycles, then handshakes and scores it.
  task automatic get_result(input int hold);
    int t = 0;
    logic [W-1:0] snap, exp;
    while (!io.res_valid && t < 20) begin @(negedge clk); t++; end
    n_tests++;
    if (!io.res_valid) begin
      n_fail++; $display("FAIL res_timeout res_valid=%0b required 1", io.res_valid);
      return;
    end
    snap = io.res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_tests++;
      if ({io.res_valid, io.res_data, io.in_ready} !== {1'b1, snap, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d valid/data/in_ready=%0b/%0h/%0b required 1/%0h/0",
                 i, io.res_valid, io.res_data, io.in_ready, snap);
      end
    end
    io.res_ready = 1'b1;
    @(negedge clk);
    io.res_ready = 1'b0;
    n_txn++;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    n_tests++;
    if (snap !== exp) begin
      n_fail++; $display("FAIL res_data got=%0h required %0h", snap, exp);
    end
    n_tests++;
    if ({io.res_valid, io.in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL post_handshake valid/in_ready/busy=%0b%0b%0b required 010",
               io.res_valid, io.in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({a, b, c, f, ctrl, io.res_data, io.res_valid, io.in_ready, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals a=%0h b=%0h c=%0h f=%0h ctrl=%0b rd=%0h rv=%0b ir=%0b busy=%0b required all 0",
               a, b, c, f, ctrl, io.res_data, io.res_valid, io.in_ready, busy);
    end
    rst_n = 1'b1;
    n_tests++;
    if (io.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_release got=%0b required 0", io.in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (io.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle got=%0b required 1", io.in_ready);
    end
  endtask

  task automatic test_basic();
    send_seq(5'd3, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({a, b, c, f, ctrl} !== {5'd3, 5'd1, 5'd0, 5'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_operands a=%0d b=%0d c=%0d f=%0d ctrl=%0b required 3 1 0 3 0",
               a, b, c, f, ctrl);
    end
    n_tests++;
    if ({io.res_valid, busy, io.in_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL exec_state valid/busy/in_ready=%0b%0b%0b required 010",
               io.res_valid, busy, io.in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (io.res_valid !== 1'b1) begin
      n_fail++; $display("FAIL latency res_valid=%0b required 1", io.res_valid);
    end
    get_result(0);
  endtask

  task automatic test_backpressure();
    send_seq(5'd3, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if ({f, ctrl} !== {5'd7, 1'b1}) begin
      n_fail++; $display("FAIL bp_operands f=%0d ctrl=%0b required 7 1", f, ctrl);
    end
    get_result(5);
  endtask

  task automatic test_bubbles();
    // ctrl is driven inverted on the first three beats; only the 4th must land
    send_seq(5'd9, 5'd18, 5'd27, 5'd4, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({a, b, c, f, ctrl} !== {5'd9, 5'd18, 5'd27, 5'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL bubble_operands a=%0d b=%0d c=%0d f=%0d ctrl=%0b required 9 18 27 4 1",
               a, b, c, f, ctrl);
    end
    get_result(1);
  endtask

  task automatic test_mid_reset();
    send_beat(5'd11, 1'b0);
    send_beat(5'd12, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({a, b, c, f, ctrl, io.res_valid, io.in_ready, busy, io.res_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset a=%0h b=%0h rv=%0b ir=%0b busy=%0b required all 0",
               a, b, io.res_valid, io.in_ready, busy);
    end
    @(negedge clk);
    send_seq(5'd1, 5'd2, 5'd4, 5'd8, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({a, b, c, f} !== {5'd1, 5'd2, 5'd4, 5'd8}) begin
      n_fail++;
      $display("FAIL fresh_operands a=%0d b=%0d c=%0d f=%0d required 1 2 4 8", a, b, c, f);
    end
    get_result(0);
  endtask

  task automatic test_stub_d();
    d_ovr = 1'b1; d_val = 5'b10101;
    send_seq(5'd6, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(5'b10101);
    @(negedge clk);       // now in DONE with d already captured
    d_val = '0;
    get_result(3);
    d_ovr = 1'b0;
  endtask

  task automatic test_back_to_back();
    // each sequence starts on the cycle right after the previous handshake
    for (int i = 0; i < 3; i++) begin
      send_seq(W'(i * 7), W'(i + 3), W'(i * 5 + 1), W'(30 - i), 1'(i), 1'b0, 1'b1);
      get_result(0);
    end
  endtask

`ifdef EXEC01_SEQ_COUNT_EN
  task automatic test_count();
    test_reset();
    for (int i = 0; i < 257; i++) begin
      send_seq(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
               1'($urandom), 1'b0, 1'b1);
      get_result(0);
      if (i == 255) begin
        n_tests++;
        if (txn_count !== 8'd0) begin
          n_fail++; $display("FAIL count_wrap got=%0d required 0", txn_count);
        end
      end
    end
    n_tests++;
    if (txn_count !== 8'd1) begin
      n_fail++; $display("FAIL count_257 got=%0d required 1", txn_count);
    end
  endtask
`endif

  initial begin
    io.in_valid = 1'b0; io.in_data = '0; io.in_ctrl = 1'b0; io.res_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_stub_d();
    test_back_to_back();
`ifdef EXEC01_SEQ_COUNT_EN
    test_count();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left got=%0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
